ofifo_drain: RTL and testbench

- Consumer-side controller for the per-column output FIFO bank at the bottom of the MAC array.
- Waits until every column has a result, pops one full row at a time, and applies an optional per-lane leaky-ReLU.
- Writes each row as one word into the psum SRAM at consecutive addresses.
- Runs one programmed batch of rows per start command, then pulses done.

---
 rtl/ofifo_drain_pkg.sv | 21 ++
 rtl/ofifo_drain_leaky_lane.sv | 20 ++
 rtl/ofifo_drain.sv | 115 +++++++++++
 tb/tb_ofifo_drain.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofifo_drain_pkg.sv
// Shared types and defaults for the output-FIFO drain controller and the FIFO bank it serves.
package ofifo_drain_pkg;

   localparam int COL_DEF    = 8;
   localparam int BW_DEF     = 16;
   localparam int ADDR_W_DEF = 11;
   localparam int SH_W_DEF   = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   // LSB position of lane i in a packed row of w-bit lanes
   function automatic int lane_lsb(input int i, input int w);
      return i * w;
   endfunction

endpackage

// File: rtl/ofifo_drain_leaky_lane.sv
// Single-lane leaky-ReLU: negative lanes are arithmetically shifted right when enabled.
module leaky_lane #(
   parameter int bw   = 16,
   parameter int sh_w = 3
) (
   input  logic [bw-1:0]   lane_in,
   input  logic            relu_en,
   input  logic [sh_w-1:0] shift,
   output logic [bw-1:0]   lane_out
);

   logic signed [bw-1:0] lane_s;
   logic [bw-1:0]        shifted;

   // kept as a separate assignment so the shift stays in a signed context
   assign lane_s   = $signed(lane_in);
   assign shifted  = lane_s >>> shift;
   assign lane_out = (relu_en && lane_in[bw-1]) ? shifted : lane_in;

endmodule

// File: rtl/ofifo_drain.sv
// Drains full rows from the per-column output FIFO bank into the psum SRAM,
// applying an optional per-lane leaky-ReLU; one batch per start, then done.
//
// state | meaning
// IDLE  | waiting for start; zero-length start pulses done next cycle
// DRAIN | popping rows, at most one every two cycles
// FLUSH | all pops issued; waiting for the last capture to reach the SRAM
// DONE  | one-cycle done pulse, then back to IDLE
module ofifo_drain
   import ofifo_drain_pkg::*;
#(
   parameter int col    = COL_DEF,
   parameter int bw     = BW_DEF,
   parameter int addr_w = ADDR_W_DEF,
   parameter int sh_w   = SH_W_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [addr_w-1:0]   base_addr,
   input  logic [addr_w-1:0]   num_rows,
   input  logic                relu_en,
   input  logic [sh_w-1:0]     leak_shift,
   input  logic                fifo_valid,
   output logic                fifo_rd,
   input  logic [col*bw-1:0]   fifo_out,
   output logic                mem_wr,
   output logic [addr_w-1:0]   mem_addr,
   output logic [col*bw-1:0]   mem_din,
   output logic                busy,
   output logic                done
);

   state_t              state, state_nx;
   logic [addr_w-1:0]   remaining;
   logic [addr_w-1:0]   wr_ptr;
   logic                relu_q;
   logic [sh_w-1:0]     shift_q;
   logic                rd_d1;
   logic                done_z;
   logic                accept;
   logic [col*bw-1:0]   act_row;

   assign accept = (state == IDLE) && start && (num_rows != '0);

   always_comb begin
      state_nx = state;
      fifo_rd  = 1'b0;
      case (state)
         IDLE:  if (accept) state_nx = DRAIN;
         DRAIN: begin
            // rd_d1 blocks back-to-back pops, covering the one-cycle-stale fifo_valid
            fifo_rd = fifo_valid && !rd_d1 && (remaining != '0);
            if (fifo_rd && remaining == addr_w'(1)) state_nx = FLUSH;
         end
         FLUSH: if (!rd_d1) state_nx = DONE;
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         remaining <= '0;
         wr_ptr    <= '0;
         relu_q    <= 1'b0;
         shift_q   <= '0;
         rd_d1     <= 1'b0;
         done_z    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_din   <= '0;
      end else begin
         state  <= state_nx;
         rd_d1  <= fifo_rd;
         mem_wr <= rd_d1;
         done_z <= (state == IDLE) && start && (num_rows == '0);

         if (accept) begin
            remaining <= num_rows;
            relu_q    <= relu_en;
            shift_q   <= leak_shift;
         end else if (fifo_rd) begin
            remaining <= remaining - addr_w'(1);
         end

         if (accept)     wr_ptr <= base_addr;
         else if (rd_d1) wr_ptr <= wr_ptr + addr_w'(1);

         // the popped row is on fifo_out the cycle after fifo_rd
         if (rd_d1) begin
            mem_din  <= act_row;
            mem_addr <= wr_ptr;
         end
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE) || done_z;

   for (genvar i = 0; i < col; i++) begin : g_lane
      localparam int LSB = lane_lsb(i, bw);
      leaky_lane #(
         .bw   (bw),
         .sh_w (sh_w)
      ) u_lane (
         .lane_in  (fifo_out[LSB +: bw]),
         .relu_en  (relu_q),
         .shift    (shift_q),
         .lane_out (act_row[LSB +: bw])
      );
   end

endmodule

// File: tb/tb_ofifo_drain.sv
// Bench for ofifo_drain: FIFO bank model, queue-based write scoreboard, directed and random batches.
module tb_ofifo_drain;
   import ofifo_drain_pkg::*;

   localparam int W = COL_DEF * BW_DEF;

   logic          clk = 1'b0;
   logic          reset, start, relu_en;
   logic          fifo_valid = 1'b0;
   logic          fifo_rd, mem_wr, busy, done;
   logic [10:0]   base_addr, num_rows, mem_addr;
   logic [2:0]    leak_shift;
   logic [W-1:0]  fifo_out = '0;
   logic [W-1:0]  mem_din;

   always #5 clk = ~clk;

   ofifo_drain dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .base_addr  (base_addr),
      .num_rows   (num_rows),
      .relu_en    (relu_en),
      .leak_shift (leak_shift),
      .fifo_valid (fifo_valid),
      .fifo_rd    (fifo_rd),
      .fifo_out   (fifo_out),
      .mem_wr     (mem_wr),
      .mem_addr   (mem_addr),
      .mem_din    (mem_din),
      .busy       (busy),
      .done       (done)
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // FIFO bank: registered pop, fifo_valid reflects a pop one cycle late
   logic [W-1:0] bank_q[$];
   int           bank_sz;
   always @(posedge clk) begin
      bank_sz = bank_q.size();
      if (fifo_rd) begin
         if (bank_sz > 0) fifo_out <= bank_q.pop_front();
         else chk("pop_empty", 1, 0);
      end
      fifo_valid <= (bank_sz > 0);
   end

   // scoreboard of expected SRAM writes
   logic [10:0]  exp_a[$];
   logic [W-1:0] exp_d[$];
   int cyc = 0, wr_cnt = 0, done_cnt = 0, last_wr_cyc = 0, done_cyc = 0;
   logic prev_rd = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         prev_rd = 1'b0;
      end else begin
         if (fifo_rd) chk("rd_spacing", prev_rd, 0);
         prev_rd = fifo_rd;
         if (mem_wr) begin
            if (exp_a.size() == 0) begin
               chk("unexpected_wr", 1, 0);
            end else begin
               chk("wr_addr", mem_addr, exp_a.pop_front());
               chk("wr_data", mem_din, exp_d.pop_front());
            end
            wr_cnt++;
            last_wr_cyc = cyc;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   // reference activation: floor division by 2^sh for negative lanes
   function automatic logic [W-1:0] act_row(input logic [W-1:0] row, input bit relu, input int sh);
      logic [W-1:0] res;
      int v, r, div;
      div = 1 << sh;
      for (int i = 0; i < COL_DEF; i++) begin
         v = int'($signed(row[BW_DEF*i +: BW_DEF]));
         if (relu && v < 0) r = -((-v + div - 1) / div);
         else r = v;
         res[BW_DEF*i +: BW_DEF] = r[15:0];
      end
      return res;
   endfunction

   function automatic logic [W-1:0] rnd_row();
      logic [W-1:0] r;
      for (int i = 0; i < W/32; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   logic [10:0] cur_addr;
   bit          cur_relu;
   int          cur_sh;

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic begin_batch(input logic [10:0] b, input logic [10:0] n, input bit r, input int s);
      cur_addr   = b;
      cur_relu   = r;
      cur_sh     = s;
      base_addr  = b;
      num_rows   = n;
      relu_en    = r;
      leak_shift = 3'(s);
   endtask

   task automatic push_row(input logic [W-1:0] row);
      bank_q.push_back(row);
      exp_a.push_back(cur_addr);
      exp_d.push_back(act_row(row, cur_relu, cur_sh));
      cur_addr = cur_addr + 11'd1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int d0, input string tag);
      int k = 0;
      while (done_cnt == d0 && k < 400) begin
         tick();
         k++;
      end
      chk({tag, "_done_seen"}, W'(done_cnt != d0), 1);
   endtask

   task automatic finish_checks(input int d0, input string tag);
      chk({tag, "_done_after_wr"}, W'(done_cyc), W'(last_wr_cyc + 1));
      tick();
      chk({tag, "_busy_low"}, busy, 0);
      repeat (3) tick();
      chk({tag, "_single_done"}, W'(done_cnt), W'(d0 + 1));
      chk({tag, "_all_written"}, W'(exp_a.size()), 0);
   endtask

   task automatic run_batch(input logic [10:0] b, input int n, input bit r, input int s, input string tag);
      int d0;
      d0 = done_cnt;
      begin_batch(b, 11'(n), r, s);
      for (int i = 0; i < n; i++) push_row(rnd_row());
      pulse_start();
      chk({tag, "_busy_high"}, busy, 1);
      wait_done(d0, tag);
      finish_checks(d0, tag);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_fifo_rd"}, fifo_rd, 0);
      chk({tag, "_mem_wr"}, mem_wr, 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_mem_din"}, mem_din, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
   endtask

   initial begin
      int d0, w0, k;
      logic [W-1:0] r;

      reset = 1'b1; start = 1'b0; base_addr = '0; num_rows = '0;
      relu_en = 1'b0; leak_shift = '0;
      repeat (3) tick();
      chk_outputs_zero("reset");
      reset = 1'b0;
      tick();

      run_batch(11'h010, 4, 0, 0, "basic");

      // leaky-ReLU, shift 3: {-64,40,-1,0} -> {-8,40,-1,0}
      d0 = done_cnt;
      begin_batch(11'h040, 1, 1, 3);
      r = rnd_row();
      r[63:0] = {16'h0000, 16'hFFFF, 16'd40, 16'hFFC0};
      push_row(r);
      pulse_start();
      wait_done(d0, "leaky3");
      finish_checks(d0, "leaky3");
      chk("leaky3_lanes", W'(mem_din[63:0]), W'({16'h0000, 16'hFFFF, 16'd40, 16'hFFF8}));

      d0 = done_cnt;
      begin_batch(11'h050, 1, 1, 0);
      push_row(r);
      pulse_start();
      wait_done(d0, "leaky0");
      finish_checks(d0, "leaky0");
      chk("leaky0_row", mem_din, r);

      // stall: two rows available, then 10 cycles with an empty bank, then the last row
      d0 = done_cnt;
      w0 = wr_cnt;
      begin_batch(11'h080, 3, 1, 2);
      push_row(rnd_row());
      push_row(rnd_row());
      pulse_start();
      k = 0;
      while (wr_cnt < w0 + 2 && k < 100) begin tick(); k++; end
      chk("stall_first_rows", W'(wr_cnt), W'(w0 + 2));
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("stall_no_activity", {fifo_rd, mem_wr, done}, 0);
      end
      chk("stall_busy_kept", busy, 1);
      push_row(rnd_row());
      wait_done(d0, "stall");
      finish_checks(d0, "stall");

      run_batch(11'h7FE, 3, 1, $urandom_range(0, 7), "wrap");

      // zero length: done next cycle, no busy, no pop even with data waiting
      d0 = done_cnt;
      bank_q.push_back(rnd_row());
      repeat (2) tick();
      begin_batch(11'h123, 0, 0, 0);
      pulse_start();
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("zero_idle", {fifo_rd, busy, done}, 0);
      end
      chk("zero_single_done", W'(done_cnt), W'(d0 + 1));
      bank_q.delete();
      tick();

      // reset after the 2nd of 5 writes
      d0 = done_cnt;
      w0 = wr_cnt;
      begin_batch(11'h100, 5, 0, 0);
      for (int i = 0; i < 5; i++) push_row(rnd_row());
      pulse_start();
      k = 0;
      while (wr_cnt < w0 + 2 && k < 100) begin tick(); k++; end
      chk("rst_two_writes", W'(wr_cnt), W'(w0 + 2));
      reset = 1'b1;
      tick();
      chk_outputs_zero("rst_mid");
      reset = 1'b0;
      bank_q.delete();
      exp_a.delete();
      exp_d.delete();
      repeat (5) tick();
      chk("rst_no_done", W'(done_cnt), W'(d0));
      run_batch(11'h555, 3, 1, 1, "after_rst");

      // start while busy is ignored
      d0 = done_cnt;
      begin_batch(11'h200, 4, 0, 0);
      for (int i = 0; i < 4; i++) push_row(rnd_row());
      pulse_start();
      repeat (2) tick();
      base_addr = 11'h300; num_rows = 11'd7; relu_en = 1'b1; leak_shift = 3'd5;
      pulse_start();
      base_addr = 11'h200; num_rows = 11'd4; relu_en = 1'b0; leak_shift = 3'd0;
      wait_done(d0, "busy_start");
      finish_checks(d0, "busy_start");

      for (int t = 0; t < 3; t++)
         run_batch(11'($urandom), $urandom_range(1, 6), 1'($urandom), $urandom_range(0, 7), "rand");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
